// File: rtl/axil_cfg_regfile.sv
// rtl/axil_cfg_regfile.sv - AXI4-Lite responder for the MemorEDF configuration register bank
module axil_cfg_regfile #(
  parameter int                    ADDR_WIDTH = 40,
  parameter int                    DATA_WIDTH = 128,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 40'h8000000000,
  parameter int                    NUM_REGS   = 16
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic [2:0]                     s_axi_awprot,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic [2:0]                     s_axi_arprot,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] cfg_regs,
  output logic [NUM_REGS-1:0]            cfg_wr_pulse
);

  localparam int         STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_DEC   = 2'b11;

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  aw_held, w_held, aw_hit_q;
  logic [3:0]            aw_idx_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;

  function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] a);
    return (a[ADDR_WIDTH-1:23] == BASE_ADDR[ADDR_WIDTH-1:23]) && (a[20:19] == 2'b00);
  endfunction

  function automatic logic [3:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    return {a[22:21], a[18:17]};
  endfunction

  logic                  aw_fire, w_fire, commit;
  logic                  cur_hit, ar_hit;
  logic [3:0]            cur_idx, ar_idx;
  logic [DATA_WIDTH-1:0] cur_data;
  logic [STRB_WIDTH-1:0] cur_strb;

  // A channel captured in an earlier cycle comes from its holding register,
  // otherwise straight from the bus so a same-cycle AW+W commits at once.
  assign aw_fire  = s_axi_awvalid && s_axi_awready;
  assign w_fire   = s_axi_wvalid && s_axi_wready;
  assign commit   = (w_state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);
  assign cur_hit  = aw_held ? aw_hit_q : addr_hit(s_axi_awaddr);
  assign cur_idx  = aw_held ? aw_idx_q : addr_idx(s_axi_awaddr);
  assign cur_data = w_held ? w_data_q : s_axi_wdata;
  assign cur_strb = w_held ? w_strb_q : s_axi_wstrb;
  assign ar_hit   = addr_hit(s_axi_araddr);
  assign ar_idx   = addr_idx(s_axi_araddr);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b1;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      cfg_wr_pulse  <= '0;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_hit_q      <= 1'b0;
      aw_idx_q      <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      cfg_wr_pulse <= '0;
      case (w_state)
        W_IDLE: begin
          if (commit) begin
            if (cur_hit) begin
              for (int k = 0; k < STRB_WIDTH; k++)
                if (cur_strb[k]) regs[cur_idx][k*8 +: 8] <= cur_data[k*8 +: 8];
              cfg_wr_pulse[cur_idx] <= 1'b1;
            end
            s_axi_bresp   <= cur_hit ? RESP_OKAY : RESP_DEC;
            s_axi_bvalid  <= 1'b1;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            w_state       <= W_RESP;
          end else begin
            if (aw_fire) begin
              aw_held       <= 1'b1;
              aw_hit_q      <= addr_hit(s_axi_awaddr);
              aw_idx_q      <= addr_idx(s_axi_awaddr);
              s_axi_awready <= 1'b0;
            end
            if (w_fire) begin
              w_held       <= 1'b1;
              w_data_q     <= s_axi_wdata;
              w_strb_q     <= s_axi_wstrb;
              s_axi_wready <= 1'b0;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
      endcase
    end
  end

  // Reads sample regs before the write block's update lands, so a
  // same-cycle read of a register being written returns the old value.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b1;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_axi_arvalid) begin
            s_axi_rdata   <= ar_hit ? regs[ar_idx] : '0;
            s_axi_rresp   <= ar_hit ? RESP_OKAY : RESP_DEC;
            s_axi_rvalid  <= 1'b1;
            s_axi_arready <= 1'b0;
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
            r_state       <= R_IDLE;
          end
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign cfg_regs[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[16:0], s_axi_araddr[16:0]};

endmodule

// File: tb/tb_axil_cfg_regfile.sv
// tb/tb_axil_cfg_regfile.sv - directed self-checking bench for axil_cfg_regfile
module tb_axil_cfg_regfile;

  logic          aclk;
  logic          aresetn;
  logic [39:0]   s_axi_awaddr;
  logic [2:0]    s_axi_awprot;
  logic          s_axi_awvalid;
  logic          s_axi_awready;
  logic [127:0]  s_axi_wdata;
  logic [15:0]   s_axi_wstrb;
  logic          s_axi_wvalid;
  logic          s_axi_wready;
  logic [1:0]    s_axi_bresp;
  logic          s_axi_bvalid;
  logic          s_axi_bready;
  logic [39:0]   s_axi_araddr;
  logic [2:0]    s_axi_arprot;
  logic          s_axi_arvalid;
  logic          s_axi_arready;
  logic [127:0]  s_axi_rdata;
  logic [1:0]    s_axi_rresp;
  logic          s_axi_rvalid;
  logic          s_axi_rready;
  logic [2047:0] cfg_regs;
  logic [15:0]   cfg_wr_pulse;

  int tests = 0;
  int fails = 0;
  logic [127:0] exp_regs [16];

  axil_cfg_regfile dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .cfg_regs(cfg_regs), .cfg_wr_pulse(cfg_wr_pulse)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic logic [39:0] reg_addr(input int i);
    logic [3:0] b;
    b = i[3:0];
    return 40'h8000000000 | ({38'd0, b[3:2]} << 21) | ({38'd0, b[1:0]} << 17);
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_write(input logic [39:0] a, input logic [127:0] d, input logic [15:0] s,
                          input int aw_dly, input int w_dly,
                          output logic [1:0] resp, output logic [15:0] pulse,
                          output logic [15:0] pulse_next, output int lat);
    bit aw_done, w_done, aw_hs, w_hs;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    while (!(aw_done && w_done) && cyc < 50) begin
      s_axi_awvalid = !aw_done && (cyc >= aw_dly);
      s_axi_wvalid  = !w_done && (cyc >= w_dly);
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      tick();
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      cyc++;
    end
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    lat = 0;
    while (!s_axi_bvalid && lat < 20) begin
      tick();
      lat++;
    end
    if (!s_axi_bvalid) begin
      $display("FAIL write_timeout addr=%h got bvalid=0 expected 1", a);
      lat = -1;
    end
    resp = s_axi_bresp;
    pulse = cfg_wr_pulse;
    s_axi_bready = 1;
    tick();
    s_axi_bready = 0;
    pulse_next = cfg_wr_pulse;
  endtask

  task automatic do_read(input logic [39:0] a, output logic [127:0] d, output logic [1:0] resp);
    int n;
    s_axi_araddr = a;
    s_axi_arvalid = 1;
    n = 0;
    while (!s_axi_arready && n < 20) begin
      tick();
      n++;
    end
    tick();
    s_axi_arvalid = 0;
    if (!s_axi_rvalid) $display("FAIL read_timeout addr=%h got rvalid=0 expected 1", a);
    d = s_axi_rdata;
    resp = s_axi_rresp;
    s_axi_rready = 1;
    tick();
    s_axi_rready = 0;
  endtask

  task automatic check_model(input string name);
    tests++;
    for (int i = 0; i < 16; i++) begin
      if (cfg_regs[i*128 +: 128] !== exp_regs[i]) begin
        $display("FAIL %s reg%0d got %h expected %h", name, i, cfg_regs[i*128 +: 128], exp_regs[i]);
        fails++;
        break;
      end
    end
  endtask

  task automatic test_reset();
    aresetn = 0;
    tick(); tick();
    tests++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid} !== 5'b11100) begin
      $display("FAIL reset_handshake got %b expected 11100",
               {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid});
      fails++;
    end
    tests++;
    if ({s_axi_bresp, s_axi_rresp, s_axi_rdata, cfg_wr_pulse} !== '0) begin
      $display("FAIL reset_outputs got bresp=%h rresp=%h rdata=%h pulse=%h expected all 0",
               s_axi_bresp, s_axi_rresp, s_axi_rdata, cfg_wr_pulse);
      fails++;
    end
    for (int i = 0; i < 16; i++) exp_regs[i] = '0;
    check_model("reset_regs");
    aresetn = 1;
    tick();
  endtask

  task automatic test_first_write();
    logic [1:0] r; logic [15:0] p, pn; int lat;
    do_write(40'h8000000000, 128'h0000000000000000_0100000000000001, 16'hFFFF, 0, 0, r, p, pn, lat);
    exp_regs[0] = 128'h0000000000000000_0100000000000001;
    tests++;
    if (r !== 2'b00 || lat !== 0) begin
      $display("FAIL first_bresp got resp=%b lat=%0d expected resp=00 lat=0", r, lat); fails++;
    end
    tests++;
    if (p !== 16'h0001) begin $display("FAIL first_pulse got %h expected 0001", p); fails++; end
    tests++;
    if (pn !== 16'h0000) begin $display("FAIL first_pulse_width got %h expected 0000", pn); fails++; end
    check_model("first_regs");
  endtask

  task automatic test_strobe();
    logic [1:0] r; logic [15:0] p, pn; int lat;
    do_write(reg_addr(5), {128{1'b1}}, 16'h000F, 0, 0, r, p, pn, lat);
    exp_regs[5] = 128'h000000000000000000000000FFFFFFFF;
    tests++;
    if (r !== 2'b00 || p !== 16'h0020) begin
      $display("FAIL strobe_resp got resp=%b pulse=%h expected resp=00 pulse=0020", r, p); fails++;
    end
    check_model("strobe_regs");
  endtask

  task automatic test_split(input string name, input int reg_i, input int aw_dly, input int w_dly,
                            input logic [127:0] d);
    logic [1:0] r; logic [15:0] p, pn; logic [15:0] ep; int lat;
    do_write(reg_addr(reg_i), d, 16'hFFFF, aw_dly, w_dly, r, p, pn, lat);
    exp_regs[reg_i] = d;
    ep = 16'h0001 << reg_i;
    tests++;
    if (lat !== 0 || r !== 2'b00) begin
      $display("FAIL %s_latency got lat=%0d resp=%b expected lat=0 resp=00", name, lat, r); fails++;
    end
    tests++;
    if (p !== ep || pn !== 16'h0000) begin
      $display("FAIL %s_pulse got %h then %h expected %h then 0000", name, p, pn, ep); fails++;
    end
    check_model({name, "_regs"});
  endtask

  task automatic test_all_regs();
    logic [1:0] r; logic [15:0] p, pn; int lat; logic [127:0] d;
    for (int i = 0; i < 16; i++) begin
      do_write(reg_addr(i), 128'(i + 1), 16'hFFFF, 0, 0, r, p, pn, lat);
      exp_regs[i] = 128'(i + 1);
    end
    check_model("all_regs_flat");
    for (int i = 0; i < 16; i++) begin
      do_read(reg_addr(i), d, r);
      tests++;
      if (d !== 128'(i + 1) || r !== 2'b00) begin
        $display("FAIL all_regs_read reg%0d got %h/%b expected %h/00", i, d, r, 128'(i + 1)); fails++;
      end
    end
  endtask

  task automatic test_decerr(input logic [39:0] a);
    logic [1:0] r; logic [15:0] p, pn; int lat; logic [127:0] d;
    do_write(a, {128{1'b1}}, 16'hFFFF, 0, 0, r, p, pn, lat);
    tests++;
    if (r !== 2'b11 || p !== 16'h0000) begin
      $display("FAIL decerr_write %h got resp=%b pulse=%h expected 11/0000", a, r, p); fails++;
    end
    check_model("decerr_regs");
    do_read(a, d, r);
    tests++;
    if (r !== 2'b11 || d !== '0) begin
      $display("FAIL decerr_read %h got %h/%b expected 0/11", a, d, r); fails++;
    end
  endtask

  task automatic test_hold_reset();
    s_axi_awaddr = reg_addr(2); s_axi_wdata = 128'hABCD; s_axi_wstrb = 16'hFFFF;
    s_axi_araddr = reg_addr(2);
    s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_arvalid = 1;
    tick();
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
    tests++;
    if (cfg_wr_pulse !== 16'h0004 || cfg_regs[2*128 +: 128] !== 128'hABCD) begin
      $display("FAIL hold_commit got pulse=%h reg2=%h expected 0004/abcd",
               cfg_wr_pulse, cfg_regs[2*128 +: 128]); fails++;
    end
    for (int c = 0; c < 5; c++) begin
      tests++;
      if ({s_axi_bvalid, s_axi_rvalid, s_axi_awready, s_axi_wready, s_axi_arready} !== 5'b11000 ||
          s_axi_bresp !== 2'b00 || s_axi_rresp !== 2'b00 || s_axi_rdata !== 128'd3) begin
        $display("FAIL hold_cycle%0d got v/rdy=%b bresp=%b rresp=%b rdata=%h expected 11000/00/00/3", c,
                 {s_axi_bvalid, s_axi_rvalid, s_axi_awready, s_axi_wready, s_axi_arready},
                 s_axi_bresp, s_axi_rresp, s_axi_rdata); fails++;
      end
      tick();
    end
    aresetn = 0;
    tick();
    tests++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid} !== 5'b11100 ||
        s_axi_rdata !== '0 || cfg_wr_pulse !== '0 || cfg_regs !== '0) begin
      $display("FAIL hold_reset got rdy/v=%b rdata=%h pulse=%h regs_nonzero=%b expected 11100/0/0/0",
               {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid},
               s_axi_rdata, cfg_wr_pulse, |cfg_regs); fails++;
    end
    aresetn = 1;
    tick();
  endtask

  initial begin
    aresetn = 0;
    s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 0; s_axi_bready = 0;
    s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 0; s_axi_rready = 0;
    test_reset();
    test_first_write();
    test_strobe();
    test_split("w_before_aw", 7, 3, 0, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    test_split("aw_before_w", 9, 0, 3, 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0001);
    test_all_regs();
    test_decerr(40'h8000080000);
    test_decerr(40'h8001000000);
    test_hold_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axil_cfg_regfile.md
Name: axil_cfg_regfile

Overview:
AXI4-Lite responder (slave) holding the MemorEDF configuration register bank, the target end of the AXI4-Lite master used to program the scheduler.
- Decodes 16 128-bit registers in a sparse window and presents them as a flat vector to the MemorEDF core.
- Emits one-cycle per-register write pulses.
- Supports byte strobes, independent AW/W arrival, and one outstanding transaction per direction.

Parameters:
ADDR_WIDTH, 40, AXI address width
DATA_WIDTH, 128, AXI data width and register width
BASE_ADDR, 40'h8000000000, window base; bits [ADDR_WIDTH-1:23] must match
NUM_REGS, 16, number of registers (fixed by decode; not to be changed)

Ports:
aclk  in  1  clock
aresetn  in  1  reset
s_axi_awaddr  in  ADDR_WIDTH  write address
s_axi_awprot  in  3  ignored
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8  byte strobes
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
s_axi_araddr  in  ADDR_WIDTH  read address
s_axi_arprot  in  3  ignored
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready
cfg_regs  out  NUM_REGS*DATA_WIDTH  register i at [i*DATA_WIDTH +: DATA_WIDTH]
cfg_wr_pulse  out  NUM_REGS  bit i high one cycle after register i is written

Behaviour:
Clock and reset:
- Single clock aclk; reset aresetn is synchronous and active-low.
- On reset:
  - All registers = 0.
  - awready = wready = arready = 1.
  - bvalid = rvalid = 0; bresp = rresp = 0; rdata = 0; cfg_wr_pulse = 0.
- Reset mid-transaction abandons it; no partial register update.

Decode:
- idx = {addr[22:21], addr[18:17]}.
- The address hits when addr[ADDR_WIDTH-1:23] == BASE_ADDR[ADDR_WIDTH-1:23] and addr[20:19] == 0.
- addr[16:0] is ignored.
- A miss gives DECERR (2'b11): writes are dropped, reads return rdata = 0.
- A hit gives OKAY (2'b00).

Write FSM, states W_IDLE / W_RESP:
- In W_IDLE:
  - awready stays 1 until AW is captured, then 0; wready likewise for W.
  - AW and W may handshake in the same cycle or in either order, any number of cycles apart.
- In the cycle both are held:
  - Commit the write. Byte k of reg[idx] updates iff wstrb[k].
  - Set cfg_wr_pulse[idx] = 1 for exactly the next cycle, on a hit only, even if wstrb = 0.
  - Set bvalid = 1 with bresp, and go to W_RESP.
- In W_RESP:
  - awready = wready = 0.
  - On bvalid && bready: bvalid = 0, awready = wready = 1, back to W_IDLE.
- Minimum write turnaround is AW/W handshake → bvalid on the next cycle.

Read FSM, states R_IDLE / R_DATA:
- In R_IDLE, arready = 1.
- On AR handshake:
  - Capture rdata = reg[idx] (or 0) and rresp.
  - Set rvalid = 1 on the next cycle, with arready = 0.
- In R_DATA:
  - rdata and rresp hold stable while rvalid && !rready.
  - On rready: rvalid = 0, arready = 1.

Read and write interaction:
- The read and write paths are fully independent and may run concurrently.
- If a read handshake and a write commit to the same register fall in the same cycle, the read returns the pre-write value.

Test Plan:
- Reset, then a write to 40'h8000000000 with data 128'h…0100000000000001 and wstrb = all ones → bresp = 0; cfg_regs[127:0] matches the data; cfg_wr_pulse = 16'h0001 for one cycle.
- Write all 16 addresses (8000000000, 8000020000, …, 8000660000) with data 1..16, then read each back → rdata equals the data written, rresp = 0, and register i sits at cfg_regs slice i.
- W presented 3 cycles before AW, and separately AW 3 cycles before W → single commit each time; bvalid rises the cycle after the later handshake.
- Write reg 5 with wstrb = 16'h000F and data 128'hFFFF…FF over an initial 0 → reg 5 = 128'h000000000000000000000000FFFFFFFF.
- Write 40'h8000080000 (addr[20:19] != 0) and 40'h8001000000 (base mismatch) → bresp = 2'b11 with no register or pulse change; a read of the same address gives rresp = 2'b11 and rdata = 0.
- Hold bready = 0 and rready = 0 for 5 cycles → bvalid/rvalid, data and resp stay stable, awready/wready/arready stay 0; assert aresetn = 0 mid-hold → everything returns to reset values on the next edge.
